// File: rtl/stopwatch_datapath_pkg.sv
// ==========================================================================
// stopwatch_datapath_pkg : FSM encodings and packed time-word layout. Rev 1.0
// ==========================================================================
`default_nettype none

package stopwatch_datapath_pkg;

   localparam logic [1:0] ST_STOP  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam int MSEC_W = 7;
   localparam int TIME_W = HOUR_W + MIN_W + SEC_W + MSEC_W;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;
   localparam int MSEC_MAX = 99;

   // Field positions inside the packed word; the FND controller splits on these.
   localparam int MSEC_LSB = 0;
   localparam int SEC_LSB  = MSEC_LSB + MSEC_W;
   localparam int MIN_LSB  = SEC_LSB + SEC_W;
   localparam int HOUR_LSB = MIN_LSB + MIN_W;

endpackage

`default_nettype wire

// File: rtl/stopwatch_datapath_time_field_counter.sv
// ==========================================================================
// time_field_counter : wrapping 0..MAX_VAL counter with carry-out. Rev 1.0
// ==========================================================================
`default_nettype none

module time_field_counter #(
   parameter int WIDTH   = 7,
   parameter int MAX_VAL = 99
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] value,
   output logic             carry_out
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_VAL);

   logic at_max;

   assign at_max    = (value == LAST);
   assign carry_out = inc && at_max;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (inc) begin
         value <= at_max ? '0 : value + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stopwatch_datapath.sv
// ==========================================================================
// stopwatch_datapath : run/stop/clear FSM, centisecond prescaler, hh:mm:ss.cc. Rev 1.0
// ==========================================================================
`default_nettype none

module stopwatch_datapath
   import stopwatch_datapath_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_run_stop,
   input  logic              i_clear,
   output logic [TIME_W-1:0] o_time_data,
   output logic              o_running,
   output logic              o_tick
);

   localparam int DIV   = CLK_FREQ / TICK_HZ;
   localparam int PRE_W = $clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic             run_adv;
   logic             clear_all;
   logic [PRE_W-1:0] presc;
   logic             tick;

   logic [MSEC_W-1:0] msec;
   logic [SEC_W-1:0]  sec;
   logic [MIN_W-1:0]  min;
   logic [HOUR_W-1:0] hour;
   logic              msec_carry;
   logic              sec_carry;
   logic              min_carry;
   logic              unused_hour_carry;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_STOP;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_STOP: begin
            if (i_clear) begin
               next_state = ST_CLEAR;
            end else if (i_run_stop) begin
               next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_run_stop) begin
               next_state = ST_STOP;
            end
         end
         ST_CLEAR: next_state = ST_STOP;
         default:  next_state = ST_STOP;
      endcase
   end

   // The prescaler only moves while RUN persists, so a stop request on the
   // terminal-count cycle suppresses both the wrap and the tick.
   always_comb begin
      run_adv   = (state == ST_RUN) && (next_state == ST_RUN);
      clear_all = (state == ST_CLEAR);
      o_running = (state == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clear_all) begin
            presc <= '0;
         end else if (run_adv) begin
            if (presc == PRE_LAST) begin
               presc <= '0;
               tick  <= 1'b1;
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

   assign o_tick = tick;

   time_field_counter #(.WIDTH(MSEC_W), .MAX_VAL(MSEC_MAX)) u_msec (
      .clk(clk), .reset(reset), .clear(clear_all), .inc(tick),
      .value(msec), .carry_out(msec_carry)
   );

   time_field_counter #(.WIDTH(SEC_W), .MAX_VAL(SEC_MAX)) u_sec (
      .clk(clk), .reset(reset), .clear(clear_all), .inc(msec_carry),
      .value(sec), .carry_out(sec_carry)
   );

   time_field_counter #(.WIDTH(MIN_W), .MAX_VAL(MIN_MAX)) u_min (
      .clk(clk), .reset(reset), .clear(clear_all), .inc(sec_carry),
      .value(min), .carry_out(min_carry)
   );

   time_field_counter #(.WIDTH(HOUR_W), .MAX_VAL(HOUR_MAX)) u_hour (
      .clk(clk), .reset(reset), .clear(clear_all), .inc(min_carry),
      .value(hour), .carry_out(unused_hour_carry)
   );

   assign o_time_data[HOUR_LSB +: HOUR_W] = hour;
   assign o_time_data[MIN_LSB  +: MIN_W]  = min;
   assign o_time_data[SEC_LSB  +: SEC_W]  = sec;
   assign o_time_data[MSEC_LSB +: MSEC_W] = msec;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_datapath.sv
// ==========================================================================
// tb_stopwatch_datapath : directed stimulus with tick-driven scoreboard. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_stopwatch_datapath;
   import stopwatch_datapath_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_run_stop = 1'b0;
   logic        i_clear = 1'b0;
   logic [23:0] o_time_data;
   logic        o_running;
   logic        o_tick;

   int n_checks = 0;
   int n_fail   = 0;
   logic [23:0] exp_q[$];
   logic        tick_d = 1'b0;

   stopwatch_datapath #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
      .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear),
      .o_time_data(o_time_data), .o_running(o_running), .o_tick(o_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // The time word moves on the edge after a tick is seen, so compare one
   // negedge later against the oldest pending expectation.
   always @(negedge clk) begin
      if (tick_d) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_tick: actual=tick required=no_tick time=%0h", o_time_data);
         end else begin
            check("time_after_tick", o_time_data, exp_q.pop_front());
         end
      end
      tick_d = o_tick;
   end

   task automatic pulse_run();
      i_run_stop = 1'b1;
      @(negedge clk);
      i_run_stop = 1'b0;
   endtask

   task automatic wait_ticks(input int n, input int budget);
      int seen = 0;
      int cyc  = 0;
      while (seen < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (o_tick) seen++;
      end
      check("ticks_seen", seen, n);
   endtask

   task automatic cycles_to_tick(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!o_tick && c < 40);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int c, last, ticks, bad;

      // Reset held, then idle: nothing may move.
      repeat (5) @(negedge clk);
      check("reset_time", o_time_data, 24'h0);
      check("reset_running", o_running, 1'b0);
      check("reset_tick", o_tick, 1'b0);
      reset = 1'b1;
      repeat (100) @(negedge clk);
      check("idle_time", o_time_data, 24'h0);
      check("idle_running", o_running, 1'b0);

      // Run 1000 cycles: 100 ticks, 10-cycle period, ends at 00:00:01.00.
      for (int i = 1; i <= 100; i++)
         exp_q.push_back((i < 100) ? {5'd0, 6'd0, 6'd0, 7'(i)} : {5'd0, 6'd0, 6'd1, 7'd0});
      @(negedge clk);
      pulse_run();
      check("running_after_start", o_running, 1'b1);
      ticks = 0; bad = 0; last = 0;
      for (int k = 1; k <= 1001; k++) begin
         @(negedge clk);
         if (o_tick) begin
            ticks++;
            if (k - last != 10) bad++;
            last = k;
         end
      end
      @(negedge clk);
      check("tick_count_1000cyc", ticks, 100);
      check("tick_period_errors", bad, 0);
      check("time_1s", o_time_data, {5'd0, 6'd0, 6'd1, 7'd0});
      check("queue_drained_1", exp_q.size(), 0);

      // Stop 4 cycles past a tick; the held prescaler gives a tick 6 cycles after restart.
      exp_q.push_back({5'd0, 6'd0, 6'd1, 7'd1});
      cycles_to_tick(c);
      check("sync_tick_found", o_tick, 1'b1);
      repeat (4) @(negedge clk);
      pulse_run();
      check("stopped_running", o_running, 1'b0);
      repeat (50) @(negedge clk);
      check("time_held_in_stop", o_time_data, {5'd0, 6'd0, 6'd1, 7'd1});
      exp_q.push_back({5'd0, 6'd0, 6'd1, 7'd2});
      pulse_run();
      cycles_to_tick(c);
      check("restart_tick_latency", c, 6);

      // Stop right after that tick, preload 23:59:59.98, then run across midnight.
      pulse_run();
      @(negedge clk);
      force dut.u_msec.value = 7'd98;
      force dut.u_sec.value  = 6'd59;
      force dut.u_min.value  = 6'd59;
      force dut.u_hour.value = 5'd23;
      @(negedge clk);
      release dut.u_msec.value;
      release dut.u_sec.value;
      release dut.u_min.value;
      release dut.u_hour.value;
      @(negedge clk);
      check("preload_time", o_time_data, {5'd23, 6'd59, 6'd59, 7'd98});
      exp_q.push_back({5'd23, 6'd59, 6'd59, 7'd99});
      exp_q.push_back(24'h0);
      pulse_run();
      wait_ticks(2, 40);
      repeat (2) @(negedge clk);
      check("midnight_wrap", o_time_data, 24'h0);
      check("queue_drained_2", exp_q.size(), 0);

      // Clear is ignored while running.
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      check("clear_in_run_running", o_running, 1'b1);
      exp_q.push_back({5'd0, 6'd0, 6'd0, 7'd1});
      wait_ticks(1, 20);
      repeat (2) @(negedge clk);
      check("clear_in_run_ignored", o_time_data, {5'd0, 6'd0, 6'd0, 7'd1});

      // Stop, then clear + run_stop together: clear wins for one cycle.
      pulse_run();
      check("stop_before_clear", o_running, 1'b0);
      i_clear = 1'b1;
      i_run_stop = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      i_run_stop = 1'b0;
      check("clear_state", dut.state, ST_CLEAR);
      check("clear_running", o_running, 1'b0);
      @(negedge clk);
      check("after_clear_state", dut.state, ST_STOP);
      check("after_clear_time", o_time_data, 24'h0);
      check("after_clear_presc", dut.presc, 0);
      repeat (20) @(negedge clk);
      check("after_clear_running", o_running, 1'b0);

      // Run to 00:00:12.34, then reset asynchronously between edges.
      for (int k = 1; k <= 1234; k++)
         exp_q.push_back({5'd0, 6'd0, 6'(k / 100), 7'(k % 100)});
      pulse_run();
      cycles_to_tick(c);
      check("first_tick_after_clear", c, 10);
      wait_ticks(1233, 13000);
      @(negedge clk);
      check("time_12_34", o_time_data, {5'd0, 6'd0, 6'd12, 7'd34});
      #2 reset = 1'b0;
      #1;
      check("async_reset_time", o_time_data, 24'h0);
      check("async_reset_running", o_running, 1'b0);
      check("async_reset_tick", o_tick, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("post_reset_state", dut.state, ST_STOP);
      check("post_reset_running", o_running, 1'b0);
      check("post_reset_time", o_time_data, 24'h0);
      check("queue_drained_final", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stopwatch_datapath.md
Name: stopwatch_datapath

Overview:
Upstream time source for the FND controller. Counts hours, minutes, seconds and hundredths of a second while running, under a run/stop/clear control FSM. Produces the 24-bit packed time word the display stage splits into digits. Runs on the system clock and derives its 100 Hz tick internally.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 100, centisecond tick rate in Hz. Divide ratio DIV = CLK_FREQ/TICK_HZ must be an integer ≥ 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
i_run_stop  input  1  single-cycle pulse, already debounced; toggles run/stop.
i_clear  input  1  single-cycle pulse, already debounced; zeroes the time while stopped.
o_time_data  output  24  packed time {hour[23:19], min[18:13], sec[12:7], msec[6:0]}, binary per field.
o_running  output  1  1 while FSM is in RUN.
o_tick  output  1  one-cycle pulse on every centisecond increment; used for debug and test.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: FSM = STOP, all counters 0, prescaler 0, o_time_data = 24'h0, o_running = 0, o_tick = 0.
- FSM states are STOP, RUN and CLEAR, registered.
  - STOP + i_clear -> CLEAR.
  - STOP + i_run_stop (no i_clear) -> RUN.
  - STOP + i_clear and i_run_stop in the same cycle -> CLEAR; clear wins and the run request is dropped.
  - RUN + i_run_stop -> STOP. i_clear is ignored in RUN.
  - CLEAR -> STOP unconditionally after 1 cycle. In CLEAR the prescaler and all time counters load 0. Inputs in CLEAR are ignored.
- o_running = (state == RUN), driven from a register (no combinational path from inputs).
- Prescaler:
  - Counts 0..DIV-1, and only advances in RUN.
  - In STOP it holds its value, so run/stop does not lose a partial centisecond.
  - It is zeroed only by reset or CLEAR.
  - When it equals DIV-1 in RUN, it wraps to 0 and o_tick = 1 for that cycle (registered).
- Time counters advance on the clock edge where o_tick is 1. Time output therefore lags the prescaler terminal count by 1 cycle.
  - msec: 0..99. At 99 it wraps to 0 and carries to sec.
  - sec: 0..59. Increments only on a msec carry. At 59 with a carry it wraps to 0 and carries to min.
  - min: 0..59. Same rule as sec; carries to hour.
  - hour: 0..23. At 23 with a carry it wraps to 0. 23:59:59.99 + tick -> 00:00:00.00 in one cycle; there is no overflow flag.
- All carries resolve in the same cycle (combinational ripple of the terminal-count conditions). No field ever shows an intermediate out-of-range value.
- o_time_data is a direct concatenation of the counter registers: 5+6+6+7 bits, no padding.
- A RUN -> STOP transition on the same cycle the prescaler would hit DIV-1: the state register updates first, the prescaler does not wrap, and no tick occurs.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously).
- Counter widths: $clog2(DIV) for the prescaler; fields exactly as packed above.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2).
  - Field widths (HOUR_W = 5, MIN_W = 6, SEC_W = 6, MSEC_W = 7).
  - Field limits (99, 59, 59, 23).
  - Packed bit positions, shared with the FND controller.
- One sub-module: time_field_counter, parameterised by WIDTH and MAX_VAL.
  - Inputs: clk, reset, clear, inc. Outputs: value, carry_out (= inc && value == MAX_VAL).
  - Instantiated four times, chained carry_out -> inc.
- Prescaler and FSM live in the top module.

Test Plan:
- Use CLK_FREQ=1000, TICK_HZ=100 (DIV=10) for all sims.
- Reset held low 5 cycles, then released, no pulses for 100 cycles -> o_time_data = 0, o_running = 0, o_tick never 1.
- i_run_stop pulse, then 1000 cycles -> o_running = 1 one cycle later; 100 ticks counted; o_time_data = {5'd0,6'd0,6'd1,7'd0}. o_tick period is exactly 10 cycles.
- Run 4 cycles past a tick, pulse i_run_stop, wait 50 cycles, pulse i_run_stop -> no tick during stop; the next tick arrives 6 running cycles after restart (prescaler held).
- Force the counters to 23:59:59.98 (via run from clear to that point, or a hierarchical preload in sim), then 2 ticks -> 23:59:59.99, then 24'h0 on the following tick, all fields wrapping in one cycle.
- In RUN pulse i_clear -> ignored, time keeps counting. Stop, pulse i_clear and i_run_stop together -> CLEAR for 1 cycle, then STOP; o_time_data = 0, prescaler 0, o_running stays 0.
- Assert reset low mid-run at time 00:00:12.34 -> o_time_data = 0 and o_running = 0 with no clock edge needed; after release the block is in STOP.
